// File: rtl/imem_port_arbiter_if.sv
// Bundle of requester, freeze and memory-side signals around imem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  logic              freeze_if;
  logic              freeze_pipe;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata, freeze_if, freeze_pipe,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata, freeze_if, freeze_pipe,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data requesters.
// Define ARB_ROUND_ROBIN_EN to alternate ties; otherwise data always beats fetch.
module imem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              grant_dm_reg, grant_dm_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              pick_dm;
  logic              if_ready_w;
  logic              dm_ready_w;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won last; a tie goes to the other side so neither starves.
  logic last_dm_reg, last_dm_next;

  assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm_reg <= 1'b0;
    end else begin
      last_dm_reg <= last_dm_next;
    end
  end

  always_comb begin
    last_dm_next = last_dm_reg;
    if (state_reg == IDLE && (bus.if_req || bus.dm_req)) begin
      last_dm_next = pick_dm;
    end
  end
`else
  assign pick_dm = bus.dm_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      grant_dm_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      grant_dm_reg <= grant_dm_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    grant_dm_next = grant_dm_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          // Everything the access needs is captured here; later input changes are ignored.
          grant_dm_next = pick_dm;
          we_next       = pick_dm & bus.dm_we;
          addr_next     = pick_dm ? bus.dm_addr : bus.if_addr;
          wdata_next    = pick_dm ? bus.dm_wdata : '0;
          cnt_next      = CNT_LOAD;
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          if (!we_reg) begin
            if (grant_dm_reg) begin
              dm_rdata_next = bus.mem_rdata;
            end else begin
              if_rdata_next = bus.mem_rdata;
            end
          end
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state register, so an async reset clears them at once.
  assign if_ready_w      = (state_reg == RESP) & ~grant_dm_reg;
  assign dm_ready_w      = (state_reg == RESP) &  grant_dm_reg;

  assign bus.if_ready    = if_ready_w;
  assign bus.dm_ready    = dm_ready_w;
  assign bus.if_rdata    = if_rdata_reg;
  assign bus.dm_rdata    = dm_rdata_reg;
  assign bus.freeze_if   = bus.if_req & ~if_ready_w;
  assign bus.freeze_pipe = bus.dm_req & ~dm_ready_w;
  assign bus.mem_en      = (state_reg == ACCESS);
  assign bus.mem_we      = (state_reg == ACCESS) & we_reg;
  assign bus.mem_addr    = addr_reg;
  assign bus.mem_wdata   = wdata_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, corner sequences, then random
// traffic checked against a transaction-timeline model of the arbiter.
module tb_imem_port_arbiter;

  localparam int L = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rq_if;
    bit          rq_dm;
    bit          we;
    logic [31:0] a_if;
    logic [31:0] a_dm;
    logic [31:0] wd;
    logic [31:0] rd;
    int          e_if_cyc;
    int          e_dm_cyc;
    logic [31:0] e_if_data;
    logic [31:0] e_dm_data;
    logic [31:0] e_addr1;
    logic [31:0] e_wd1;
    logic [15:0] e_en;
    logic [15:0] e_we;
    logic [15:0] e_busy;
    logic [15:0] e_fi;
    logic [15:0] e_fp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Applies one record from idle and gathers per-cycle output masks over 16 cycles.
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] en_m, we_m, busy_m, fi_m, fp_m;
    logic [31:0] a1, w1;
    int ic, dc, n_if, n_dm;
    en_m = '0; we_m = '0; busy_m = '0; fi_m = '0; fp_m = '0;
    a1 = '0; w1 = '0; ic = -1; dc = -1; n_if = 0; n_dm = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.if_req   = v.rq_if;
        bus.if_addr  = v.a_if;
        bus.dm_req   = v.rq_dm;
        bus.dm_we    = v.we;
        bus.dm_addr  = v.a_dm;
        bus.dm_wdata = v.wd;
      end
      bus.mem_rdata = (k == L || k == 2 * L + 2) ? v.rd : (32'hBAD0_0000 | 32'(k));
      #1;
      en_m[k]   = bus.mem_en;
      we_m[k]   = bus.mem_we;
      busy_m[k] = bus.busy;
      fi_m[k]   = bus.freeze_if;
      fp_m[k]   = bus.freeze_pipe;
      if (k == 1) begin
        a1 = bus.mem_addr;
        w1 = bus.mem_wdata;
      end
      if (bus.if_ready) begin
        if (ic < 0) ic = k;
        n_if++;
        bus.if_req = 1'b0;
      end
      if (bus.dm_ready) begin
        if (dc < 0) dc = k;
        n_dm++;
        bus.dm_req = 1'b0;
      end
    end
    chk($sformatf("vec%0d if_ready_cycle", idx), 64'(ic), 64'(v.e_if_cyc));
    chk($sformatf("vec%0d dm_ready_cycle", idx), 64'(dc), 64'(v.e_dm_cyc));
    chk($sformatf("vec%0d if_ready_count", idx), 64'(n_if), 64'(v.e_if_cyc >= 0 ? 1 : 0));
    chk($sformatf("vec%0d dm_ready_count", idx), 64'(n_dm), 64'(v.e_dm_cyc >= 0 ? 1 : 0));
    chk($sformatf("vec%0d if_rdata", idx), 64'(bus.if_rdata), 64'(v.e_if_data));
    chk($sformatf("vec%0d dm_rdata", idx), 64'(bus.dm_rdata), 64'(v.e_dm_data));
    chk($sformatf("vec%0d mem_addr_c1", idx), 64'(a1), 64'(v.e_addr1));
    chk($sformatf("vec%0d mem_wdata_c1", idx), 64'(w1), 64'(v.e_wd1));
    chk($sformatf("vec%0d mem_en_mask", idx), 64'(en_m), 64'(v.e_en));
    chk($sformatf("vec%0d mem_we_mask", idx), 64'(we_m), 64'(v.e_we));
    chk($sformatf("vec%0d busy_mask", idx), 64'(busy_m), 64'(v.e_busy));
    chk($sformatf("vec%0d freeze_if_mask", idx), 64'(fi_m), 64'(v.e_fi));
    chk($sformatf("vec%0d freeze_pipe_mask", idx), 64'(fp_m), 64'(v.e_fp));
    $display("vec %0d: if_ready@%0d dm_ready@%0d if_rdata=%h dm_rdata=%h",
             idx, ic, dc, bus.if_rdata, bus.dm_rdata);
  endtask

  // Random-phase model: the arbiter is a timeline of grants, each occupying L+2 cycles.
  int          free_at, grant_c, done_c;
  bit          win_dm, lat_we, last_dm, if_hold, dm_hold;
  logic [31:0] lat_addr, lat_wd, m_if, m_dm;

  initial begin
    int if_first, dm_first, dm_n, exp_if_first;
    bit rdy_if, rdy_dm, in_acc, tie_dm, dm_pick;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_idle();

    vecs[0] = '{rq_if:1, rq_dm:1, we:0, a_if:32'h20, a_dm:32'h300, wd:32'h55, rd:32'h0BADF00D,
                e_if_cyc:11, e_dm_cyc:5, e_if_data:32'h0BADF00D, e_dm_data:32'h0BADF00D,
                e_addr1:32'h300, e_wd1:32'h55, e_en:16'h079E, e_we:16'h0000,
                e_busy:16'h0FBE, e_fi:16'h07FF, e_fp:16'h001F};
    vecs[1] = '{rq_if:1, rq_dm:0, we:1, a_if:32'h10, a_dm:32'h0, wd:32'h77, rd:32'hE3A01005,
                e_if_cyc:5, e_dm_cyc:-1, e_if_data:32'hE3A01005, e_dm_data:32'h0BADF00D,
                e_addr1:32'h10, e_wd1:32'h0, e_en:16'h001E, e_we:16'h0000,
                e_busy:16'h003E, e_fi:16'h001F, e_fp:16'h0000};
    vecs[2] = '{rq_if:0, rq_dm:1, we:0, a_if:32'h0, a_dm:32'h200, wd:32'h0, rd:32'h12345678,
                e_if_cyc:-1, e_dm_cyc:5, e_if_data:32'hE3A01005, e_dm_data:32'h12345678,
                e_addr1:32'h200, e_wd1:32'h0, e_en:16'h001E, e_we:16'h0000,
                e_busy:16'h003E, e_fi:16'h0000, e_fp:16'h001F};
    vecs[3] = '{rq_if:0, rq_dm:1, we:1, a_if:32'h0, a_dm:32'h100, wd:32'hDEADBEEF, rd:32'hCAFEF00D,
                e_if_cyc:-1, e_dm_cyc:5, e_if_data:32'hE3A01005, e_dm_data:32'h12345678,
                e_addr1:32'h100, e_wd1:32'hDEADBEEF, e_en:16'h001E, e_we:16'h001E,
                e_busy:16'h003E, e_fi:16'h0000, e_fp:16'h001F};

    // Reset state, observed while reset is held.
    @(negedge clk);
    #1;
    chk("rst mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst dm_rdata", 64'(bus.dm_rdata), 64'd0);
    chk("rst readies", 64'({bus.if_ready, bus.dm_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Consecutive ties with data re-requesting immediately after its first completion.
    do_reset();
    if_first = -1; dm_first = -1; dm_n = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h88;
      end
      bus.mem_rdata = $urandom;
      #1;
      if (bus.if_ready) begin
        if (if_first < 0) if_first = k;
        bus.if_req = 1'b0;
      end
      if (bus.dm_ready) begin
        if (dm_first < 0) dm_first = k;
        dm_n++;
        if (dm_n == 2) bus.dm_req = 1'b0;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_if_first = 2 * (L + 2) - 1;
`else
    exp_if_first = 3 * (L + 2) - 1;
`endif
    chk("ties dm_first", 64'(dm_first), 64'(L + 1));
    chk("ties if_first", 64'(if_first), 64'(exp_if_first));
    chk("ties dm_count", 64'(dm_n), 64'd2);
    $display("ties: dm_ready@%0d if_ready@%0d dm_count=%0d", dm_first, if_first, dm_n);

    // Fetch request dropped in the middle of its access still completes.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
      end
      if (k == 2) bus.if_req = 1'b0;
      bus.mem_rdata = (k == L) ? 32'h600DCAFE : 32'hDEAD0000 | 32'(k);
      #1;
      chk($sformatf("drop c%0d if_ready", k), 64'(bus.if_ready), 64'(k == L + 1));
      chk($sformatf("drop c%0d mem_en", k), 64'(bus.mem_en), 64'(k >= 1 && k <= L));
      if (k == L + 1) chk("drop if_rdata", 64'(bus.if_rdata), 64'h600DCAFE);
    end
    $display("drop: fetch to 0x80 completed with if_rdata=%h", bus.if_rdata);

    // Reset in the middle of a read abandons it with no ready pulse.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    @(negedge clk);
    #1;
    chk("midrst pre mem_en", 64'(bus.mem_en), 64'd1);
    chk("midrst pre mem_addr", 64'(bus.mem_addr), 64'h40);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst mem_en", 64'(bus.mem_en), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrst if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("midrst dm_rdata", 64'(bus.dm_rdata), 64'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst post c%0d ready/en", k),
          64'({bus.if_ready, bus.dm_ready, bus.mem_en}), 64'd0);
    end
    $display("midrst: access abandoned, outputs cleared");

    // Random traffic against the timeline model.
    do_reset();
    free_at = 0; grant_c = -100; done_c = -100;
    win_dm = 0; lat_we = 0; last_dm = 0; if_hold = 0; dm_hold = 0;
    lat_addr = '0; lat_wd = '0; m_if = '0; m_dm = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.if_req    = if_hold;
      bus.if_addr   = $urandom;
      bus.dm_req    = dm_hold;
      bus.dm_we     = 1'($urandom_range(0, 1));
      bus.dm_addr   = $urandom;
      bus.dm_wdata  = $urandom;
      bus.mem_rdata = $urandom;
      #1;
      rdy_if = (c == done_c) && !win_dm;
      rdy_dm = (c == done_c) && win_dm;
      in_acc = (c > grant_c) && (c < done_c);
      chk($sformatf("rnd c%0d if_ready", c), 64'(bus.if_ready), 64'(rdy_if));
      chk($sformatf("rnd c%0d dm_ready", c), 64'(bus.dm_ready), 64'(rdy_dm));
      chk($sformatf("rnd c%0d mem_en", c), 64'(bus.mem_en), 64'(in_acc));
      chk($sformatf("rnd c%0d busy", c), 64'(bus.busy), 64'((c > grant_c) && (c <= done_c)));
      chk($sformatf("rnd c%0d freeze", c), 64'({bus.freeze_if, bus.freeze_pipe}),
          64'({if_hold & ~rdy_if, dm_hold & ~rdy_dm}));
      chk($sformatf("rnd c%0d if_rdata", c), 64'(bus.if_rdata), 64'(m_if));
      chk($sformatf("rnd c%0d dm_rdata", c), 64'(bus.dm_rdata), 64'(m_dm));
      if (in_acc) begin
        chk($sformatf("rnd c%0d mem_we", c), 64'(bus.mem_we), 64'(lat_we));
        chk($sformatf("rnd c%0d mem_addr", c), 64'(bus.mem_addr), 64'(lat_addr));
        chk($sformatf("rnd c%0d mem_wdata", c), 64'(bus.mem_wdata), 64'(lat_wd));
        if (c == done_c - 1 && !lat_we) begin
          if (win_dm) m_dm = bus.mem_rdata;
          else        m_if = bus.mem_rdata;
        end
      end
      if (c >= free_at && (if_hold || dm_hold)) begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_dm = !last_dm;
`else
        tie_dm = 1'b1;
`endif
        dm_pick  = dm_hold && (!if_hold || tie_dm);
        last_dm  = dm_pick;
        win_dm   = dm_pick;
        grant_c  = c;
        done_c   = c + L + 1;
        free_at  = done_c + 1;
        lat_we   = dm_pick ? bus.dm_we : 1'b0;
        lat_addr = dm_pick ? bus.dm_addr : bus.if_addr;
        lat_wd   = dm_pick ? bus.dm_wdata : 32'h0;
      end
      if (rdy_if || rdy_dm) begin
        $display("rnd txn c=%0d port=%s we=%0d addr=%h rdata=%h",
                 c, rdy_dm ? "dm" : "if", lat_we, lat_addr, rdy_dm ? m_dm : m_if);
      end
      if (rdy_if) if_hold = 1'b0;
      else if (!if_hold && $urandom_range(0, 2) == 0) if_hold = 1'b1;
      if (rdy_dm) dm_hold = 1'b0;
      else if (!dm_hold && $urandom_range(0, 2) == 0) dm_hold = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
